// File: rtl/mem_address_sequencer.sv
// Address sequencer: issues count addresses from base with a per-mode step
// (up, bounded-wrap, down, repeat) under a valid/ready handshake.
module mem_address_sequencer #(
   parameter int ADDR_W = 8,
   parameter int OFF_W  = 2,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [OFF_W-1:0]  offset,
   input  logic [CNT_W-1:0]  count,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] limit,
   input  logic              ready,
   output logic [ADDR_W-1:0] outputAddress,
   output logic              addr_valid,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {M_UP, M_BOUND, M_DOWN, M_REPEAT} mode_t;

   state_t            state, state_nxt;
   mode_t             mode_q;
   logic [ADDR_W-1:0] addr_q, base_q, limit_q, off_ext, addr_nxt;
   logic [OFF_W-1:0]  offset_q;
   logic [CNT_W-1:0]  remaining;
   logic              wrap_q, wrap_hit, handshake;
   logic [ADDR_W:0]   sum, diff;

   assign handshake = (state == RUN) && ready;
   assign off_ext   = ADDR_W'(offset_q);

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (count != '0) ? RUN : DONE;
         RUN:     if (handshake && remaining == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      addr_valid    = (state == RUN);
      busy          = (state == RUN);
      done          = (state == DONE);
      outputAddress = addr_q;
      wrap          = wrap_q;
   end

   // Extra top bit of sum/diff carries the carry-out or borrow.
   always_comb begin
      sum      = {1'b0, addr_q} + {1'b0, off_ext};
      diff     = {1'b0, addr_q} - {1'b0, off_ext};
      addr_nxt = addr_q;
      wrap_hit = 1'b0;
      case (mode_q)
         M_UP: begin
            addr_nxt = sum[ADDR_W-1:0];
            wrap_hit = sum[ADDR_W];
         end
         M_BOUND:  addr_nxt = (sum > {1'b0, limit_q}) ? base_q : sum[ADDR_W-1:0];
         M_DOWN: begin
            addr_nxt = diff[ADDR_W-1:0];
            wrap_hit = diff[ADDR_W];
         end
         default:  addr_nxt = addr_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         base_q    <= '0;
         limit_q   <= '0;
         offset_q  <= '0;
         mode_q    <= M_UP;
         remaining <= '0;
         wrap_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               wrap_q <= 1'b0;
               if (count != '0) begin
                  addr_q    <= base;
                  base_q    <= base;
                  limit_q   <= limit;
                  offset_q  <= offset;
                  mode_q    <= mode_t'(mode);
                  remaining <= count;
               end
            end
            RUN: if (handshake) begin
               remaining <= remaining - 1'b1;
               // Only a next address that is actually issued may set wrap.
               if (remaining != CNT_W'(1)) begin
                  addr_q <= addr_nxt;
                  if (wrap_hit) wrap_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_address_sequencer.sv
// Bench for mem_address_sequencer: directed scenarios plus randomized
// sequences checked against an address-list reference model.
module tb_mem_address_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, ready;
   logic [7:0] base, limit, outputAddress;
   logic [1:0] offset, mode;
   logic [3:0] count;
   logic       addr_valid, busy, done, wrap;

   int checks = 0;
   int errors = 0;

   mem_address_sequencer #(.ADDR_W(8), .OFF_W(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .offset(offset),
      .count(count), .mode(mode), .limit(limit), .ready(ready),
      .outputAddress(outputAddress), .addr_valid(addr_valid), .busy(busy),
      .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic scramble();
      base   = 8'($urandom);
      offset = 2'($urandom);
      count  = 4'($urandom);
      mode   = 2'($urandom);
      limit  = 8'($urandom);
   endtask

   // rmode: 0 ready always high, 1 random ready and start noise, 2 ready low two cycles
   task automatic run_seq(input logic [7:0] b, input logic [1:0] o, input logic [3:0] c,
                          input logic [1:0] m, input logic [7:0] l, input int rmode);
      int  exp_a[$];
      bit  exp_w[$];
      int  a, s, idx, cyc;
      bit  wrapped, r, fin_w;
      a = b; wrapped = 0;
      for (int i = 0; i < c; i++) begin
         exp_a.push_back(a);
         exp_w.push_back(wrapped);
         case (m)
            2'd0: begin s = a + o; if (s > 255) wrapped = 1; a = s % 256; end
            2'd1: begin s = a + o; a = (s > l) ? b : s; end
            2'd2: begin if (a < o) wrapped = 1; a = (a - o + 256) % 256; end
            default: ;
         endcase
      end
      fin_w = (c == 0) ? 1'b0 : exp_w[c-1];

      base = b; offset = o; count = c; mode = m; limit = l; start = 1'b1;
      step();
      start = 1'b0;
      scramble();
      idx = 0; cyc = 0;
      while (idx < c && cyc < 200) begin
         check("run_valid", addr_valid, 1);
         check("run_busy", busy, 1);
         check("run_done", done, 0);
         check("run_addr", outputAddress, exp_a[idx]);
         check("run_wrap", wrap, exp_w[idx]);
         case (rmode)
            1:       begin r = 1'($urandom); start = 1'($urandom); end
            2:       r = (cyc >= 2);
            default: r = 1'b1;
         endcase
         ready = r;
         step();
         if (r) idx++;
         cyc++;
      end
      if (idx < c) check("run_timeout", idx, c);
      ready = 1'b0; start = 1'b0;
      check("end_done", done, 1);
      check("end_valid", addr_valid, 0);
      check("end_busy", busy, 0);
      check("end_wrap", wrap, fin_w);
      step();
      check("idle_done", done, 0);
      check("idle_valid", addr_valid, 0);
      check("idle_wrap", wrap, fin_w);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ready = 1'b0;
      base = '0; offset = '0; count = '0; mode = '0; limit = '0;
      @(negedge clk);
      step();
      check("rst_addr", outputAddress, 0);
      check("rst_valid", addr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wrap", wrap, 0);
      reset = 1'b0;
      step();

      run_seq(8'h00, 2'd1, 4'd3, 2'd0, 8'h00, 0);
      run_seq(8'hFE, 2'd2, 4'd3, 2'd0, 8'h00, 0);
      run_seq(8'h10, 2'd3, 4'd4, 2'd1, 8'h14, 0);
      run_seq(8'h05, 2'd1, 4'd2, 2'd2, 8'h00, 2);
      run_seq(8'h00, 2'd1, 4'd2, 2'd2, 8'h00, 0);
      run_seq(8'h33, 2'd1, 4'd0, 2'd0, 8'h00, 0);
      run_seq(8'h77, 2'd3, 4'd5, 2'd3, 8'h00, 1);

      // Reset on the second address of a 4-address down run that has just wrapped
      base = 8'h00; offset = 2'd1; count = 4'd4; mode = 2'd2; start = 1'b1;
      step();
      start = 1'b0; ready = 1'b1;
      check("mid_addr0", outputAddress, 8'h00);
      step();
      check("mid_addr1", outputAddress, 8'hFF);
      check("mid_wrap", wrap, 1);
      reset = 1'b1; start = 1'b1; ready = 1'b1;
      step();
      check("mid_rst_addr", outputAddress, 0);
      check("mid_rst_valid", addr_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_wrap", wrap, 0);
      reset = 1'b0; start = 1'b0; ready = 1'b0;
      step();
      check("post_rst_valid", addr_valid, 0);
      check("post_rst_done", done, 0);
      run_seq(8'h80, 2'd2, 4'd4, 2'd0, 8'h00, 0);

      for (int i = 0; i < 40; i++)
         run_seq(8'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 8'($urandom), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_address_sequencer.md
MEM_ADDRESS_SEQUENCER -- requirements
Module: mem_address_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: address width in bits.
REQ-002 SHALL have parameter OFF_W, default 2: step (offset) width in bits; the step is zero-extended to ADDR_W.
REQ-003 SHALL have parameter CNT_W, default 4: transfer-count width in bits.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a new address sequence; sampled only in IDLE.
REQ-007 SHALL have port base, input, ADDR_W: first address of the sequence.
REQ-008 SHALL have port offset, input, OFF_W: step between consecutive addresses.
REQ-009 SHALL have port count, input, CNT_W: number of addresses to issue.
REQ-010 SHALL have port mode, input, 2: 0 linear-up, 1 bounded-wrap, 2 linear-down, 3 repeat.
REQ-011 SHALL have port limit, input, ADDR_W: inclusive upper bound, used in mode 1 only.
REQ-012 SHALL have port ready, input, 1: consumer accepts outputAddress this cycle.
REQ-013 SHALL have port outputAddress, output, ADDR_W: current address.
REQ-014 SHALL have port addr_valid, output, 1: outputAddress is valid.
REQ-015 SHALL have port busy, output, 1: high in RUN.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at sequence end.
REQ-017 SHALL have port wrap, output, 1: sticky flag, set when linear arithmetic crosses 2^ADDR_W or 0.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE.
REQ-019 IDLE, start=1, count!=0: SHALL latch base, offset, count, mode and limit, clear wrap, and enter RUN; next cycle outputAddress=base and addr_valid=1.
REQ-020 IDLE, start=1, count==0: SHALL clear wrap and enter DONE; addr_valid SHALL stay 0.
REQ-021 RUN: addr_valid=1 and busy=1; a handshake is addr_valid&ready in the same cycle.
REQ-022 RUN, ready=0: outputAddress and the remaining count SHALL hold unchanged.
REQ-023 RUN, handshake with remaining==1: SHALL enter DONE; addr_valid SHALL fall on the next cycle.
REQ-024 RUN, handshake with remaining>1: SHALL decrement remaining and load the next address the following cycle, giving one address per cycle under continuous ready.
REQ-025 Mode 0: next = (addr + offset) mod 2^ADDR_W; a carry out SHALL set wrap.
REQ-026 Mode 1: SHALL compute sum = addr + offset at ADDR_W+1 bits; next = base if sum > limit, otherwise sum; wrap SHALL be unaffected.
REQ-027 Mode 2: next = (addr - offset) mod 2^ADDR_W; a borrow SHALL set wrap.
REQ-028 Mode 3: next = addr, so the same address is issued count times.
REQ-029 DONE: done=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-030 start in RUN or DONE SHALL be ignored, and in-flight latched values SHALL be unaffected by input changes.
REQ-031 wrap SHALL hold its value until the next accepted start or reset.

Reset
REQ-032 reset=1 SHALL force, at the next edge and from any state including mid-RUN: state=IDLE, outputAddress=0, addr_valid=0, busy=0, done=0, wrap=0, remaining=0.
REQ-033 reset SHALL take priority over start and ready in the same cycle.

Verification
REQ-034 base=0x00, offset=1, count=3, mode=0, ready=1 -> outputAddress 0x00,0x01,0x02 on consecutive cycles; done pulses the cycle after 0x02; wrap=0.
REQ-035 base=0xFE, offset=2, count=3, mode=0 -> 0xFE,0x00,0x02; wrap=1 from 0x00 onward and still 1 in IDLE.
REQ-036 base=0x10, limit=0x14, offset=3, count=4, mode=1 -> 0x10,0x13,0x10,0x13; done=1 once.
REQ-037 base=0x05, offset=1, count=2, mode=2, ready low for 2 cycles -> outputAddress holds 0x05 for 2 cycles, then 0x04; later base=0x00, offset=1, count=2, mode=2 -> 0x00,0xFF with wrap=1.
REQ-038 start with count=0 -> addr_valid never asserts; done=1 one cycle later; busy stays 0.
REQ-039 reset asserted on the second address of a 4-address run -> all outputs 0 next cycle; a new start is accepted afterwards and sequences from the new base.
